// File: rtl/out_fifo_sync_param.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// out_fifo_sync_param
// Single-clock output FIFO for the I/O bank data path. Each write stores NCH
// byte-wide channels. Each read beat returns one 4-bit nibble per channel.
//   "8X4": an entry is read as two beats, low nibbles first, then high nibbles.
//   "4X4": an entry is read as one beat of low nibbles; the high nibbles are dropped.
//
// Ports
//   RDCLK        clock, rising edge
//   RESET        asynchronous, active-high reset
//   WREN, D      write request and NCH*8 data (channel i = D[8i+7:8i])
//   RDEN         read-beat request
//   Q            NCH*4 read nibbles (channel i = Q[4i+3:4i])
//   EMPTY/FULL   COUNT==0 / COUNT==DEPTH
//   ALMOSTEMPTY  COUNT <= ALMOST_EMPTY_VALUE
//   ALMOSTFULL   COUNT >= DEPTH-ALMOST_FULL_VALUE
//   COUNT        stored entries (a half-read entry still counts)
//   OVERFLOW     sticky: a write was rejected
//   UNDERFLOW    sticky: a read was rejected
// ---------------------------------------------------------------------------
module out_fifo_sync_param #(
  parameter int NCH                = 10,
  parameter int DEPTH              = 8,
  parameter int ALMOST_EMPTY_VALUE = 1,
  parameter int ALMOST_FULL_VALUE  = 1,
  parameter     ARRAY_MODE         = "8X4",
  parameter bit OUTPUT_DISABLE     = 1'b0
) (
  input  logic                     RDCLK,
  input  logic                     RESET,
  input  logic                     WREN,
  input  logic [NCH*8-1:0]         D,
  input  logic                     RDEN,
  output logic [NCH*4-1:0]         Q,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic                     ALMOSTEMPTY,
  output logic                     ALMOSTFULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam bit MODE_8X4 = (ARRAY_MODE == "8X4");
  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - ALMOST_FULL_VALUE);
  localparam logic [CW-1:0] AE_LEVEL = CW'(ALMOST_EMPTY_VALUE);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

  // Reject illegal configurations at elaboration time.
  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("out_fifo_sync_param: NCH must be 1..16");
  end
  if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("out_fifo_sync_param: DEPTH must be a power of two in 4..64");
  end
  if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > DEPTH / 2) begin : g_bad_ae
    $error("out_fifo_sync_param: ALMOST_EMPTY_VALUE must be 1..DEPTH/2");
  end
  if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > DEPTH / 2) begin : g_bad_af
    $error("out_fifo_sync_param: ALMOST_FULL_VALUE must be 1..DEPTH/2");
  end
  if (ARRAY_MODE != "8X4" && ARRAY_MODE != "4X4") begin : g_bad_mode
    $error("out_fifo_sync_param: ARRAY_MODE must be \"8X4\" or \"4X4\"");
  end

  logic [NCH*8-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             phase;      // 8X4 only: 1 once the low beat of the head entry has been read
  logic             rd_ok;      // last cycle carried a successful read beat
  logic [NCH*4-1:0] q_reg;
  logic [NCH*4-1:0] beat;
  logic [CW-1:0]    count_next;
  logic             do_write;
  logic             do_read;
  logic             do_pop;
  logic             hi_beat;

  // Accept/reject decisions use the registered pre-edge FULL/EMPTY, so a pop
  // never makes room for a write on the same edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    do_write   = WREN && !FULL;
    do_read    = RDEN && !EMPTY;
    hi_beat    = MODE_8X4 && phase;
    do_pop     = do_read && (!MODE_8X4 || phase);
    count_next = COUNT;
    if (do_write && !do_pop) begin
      count_next = COUNT + CW'(1);
    end else if (!do_write && do_pop) begin
      count_next = COUNT - CW'(1);
    end
    beat = '0;
    for (int i = 0; i < NCH; i++) begin
      beat[4*i +: 4] = hi_beat ? mem[rd_ptr][8*i+4 +: 4] : mem[rd_ptr][8*i +: 4];
    end
  end

  // NOTE: the storage array has no reset; the pointers and COUNT define what is valid.
  always_ff @(posedge RDCLK) begin
    if (do_write) begin
      mem[wr_ptr] <= D;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge RDCLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      phase       <= 1'b0;
      rd_ok       <= 1'b0;
      q_reg       <= '0;
      COUNT       <= '0;
      EMPTY       <= 1'b1;
      FULL        <= 1'b0;
      ALMOSTEMPTY <= 1'b1;
      ALMOSTFULL  <= 1'b0;
      OVERFLOW    <= 1'b0;
      UNDERFLOW   <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)   rd_ptr <= rd_ptr + AW'(1);
      if (do_read && MODE_8X4) phase <= !phase;
      if (do_read)  q_reg <= beat;
      rd_ok <= do_read;
      if (WREN && FULL)  OVERFLOW  <= 1'b1;
      if (RDEN && EMPTY) UNDERFLOW <= 1'b1;
      COUNT       <= count_next;
      EMPTY       <= (count_next == '0);
      FULL        <= (count_next == FULL_LEVEL);
      ALMOSTEMPTY <= (count_next <= AE_LEVEL);
      ALMOSTFULL  <= (count_next >= AF_LEVEL);
    end
  end

  // The gate acts only on registered values, so Q has no combinational path from inputs.
  assign Q = (OUTPUT_DISABLE && !rd_ok) ? '0 : q_reg;

endmodule

// File: tb/tb_out_fifo_sync_param.sv
`timescale 1ns/1ps
// Testbench for out_fifo_sync_param. It uses three instances:
//   u_a: NCH=2, DEPTH=4, "8X4"                   fill/drain, reset mid-entry
//   u_b: NCH=2, DEPTH=4, "4X4", OUTPUT_DISABLE=1 overflow, underflow, simultaneous write/pop
//   u_c: NCH=3, DEPTH=8, AE=2, AF=2, "8X4"       thresholds, wrap, random traffic
// u_c is checked against a queue-based reference model.
module tb_out_fifo_sync_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic        a_wren = 1'b0, a_rden = 1'b0;
  logic [15:0] a_d = '0;
  logic [7:0]  a_q;
  logic        a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
  logic [2:0]  a_count;
  wire  [8:0]  a_st = {a_empty, a_full, a_ae, a_af, a_ovf, a_unf, a_count};

  out_fifo_sync_param #(.NCH(2), .DEPTH(4), .ALMOST_EMPTY_VALUE(1), .ALMOST_FULL_VALUE(1),
                        .ARRAY_MODE("8X4"), .OUTPUT_DISABLE(1'b0)) u_a (
    .RDCLK(clk), .RESET(rst), .WREN(a_wren), .D(a_d), .RDEN(a_rden), .Q(a_q),
    .EMPTY(a_empty), .FULL(a_full), .ALMOSTEMPTY(a_ae), .ALMOSTFULL(a_af),
    .COUNT(a_count), .OVERFLOW(a_ovf), .UNDERFLOW(a_unf));

  // ---------------- instance B ----------------
  logic        b_wren = 1'b0, b_rden = 1'b0;
  logic [15:0] b_d = '0;
  logic [7:0]  b_q;
  logic        b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
  logic [2:0]  b_count;
  wire  [8:0]  b_st = {b_empty, b_full, b_ae, b_af, b_ovf, b_unf, b_count};

  out_fifo_sync_param #(.NCH(2), .DEPTH(4), .ALMOST_EMPTY_VALUE(1), .ALMOST_FULL_VALUE(1),
                        .ARRAY_MODE("4X4"), .OUTPUT_DISABLE(1'b1)) u_b (
    .RDCLK(clk), .RESET(rst), .WREN(b_wren), .D(b_d), .RDEN(b_rden), .Q(b_q),
    .EMPTY(b_empty), .FULL(b_full), .ALMOSTEMPTY(b_ae), .ALMOSTFULL(b_af),
    .COUNT(b_count), .OVERFLOW(b_ovf), .UNDERFLOW(b_unf));

  // ---------------- instance C ----------------
  logic        c_wren = 1'b0, c_rden = 1'b0;
  logic [23:0] c_d = '0;
  logic [11:0] c_q;
  logic        c_empty, c_full, c_ae, c_af, c_ovf, c_unf;
  logic [3:0]  c_count;
  wire  [9:0]  c_st = {c_empty, c_full, c_ae, c_af, c_ovf, c_unf, c_count};

  out_fifo_sync_param #(.NCH(3), .DEPTH(8), .ALMOST_EMPTY_VALUE(2), .ALMOST_FULL_VALUE(2),
                        .ARRAY_MODE("8X4"), .OUTPUT_DISABLE(1'b0)) u_c (
    .RDCLK(clk), .RESET(rst), .WREN(c_wren), .D(c_d), .RDEN(c_rden), .Q(c_q),
    .EMPTY(c_empty), .FULL(c_full), .ALMOSTEMPTY(c_ae), .ALMOSTFULL(c_af),
    .COUNT(c_count), .OVERFLOW(c_ovf), .UNDERFLOW(c_unf));

  // ---------------- expectations ----------------
  // Status for DEPTH=4, ALMOST_EMPTY_VALUE=1, ALMOST_FULL_VALUE=1.
  function automatic logic [8:0] st4(input int cnt, input bit ovf, input bit unf);
    return {cnt == 0, cnt == 4, cnt <= 1, cnt >= 3, ovf, unf, 3'(cnt)};
  endfunction

  // Status for DEPTH=8, ALMOST_EMPTY_VALUE=2, ALMOST_FULL_VALUE=2.
  function automatic logic [9:0] st8(input int cnt, input bit ovf, input bit unf);
    return {cnt == 0, cnt == 8, cnt <= 2, cnt >= 6, ovf, unf, 4'(cnt)};
  endfunction

  // Low nibbles of a two-channel word, as {ch1, ch0}.
  function automatic logic [7:0] lo2(input logic [15:0] w);
    return {w[11:8], w[3:0]};
  endfunction

  // One nibble per channel of a three-channel word.
  function automatic logic [11:0] nib3(input logic [23:0] w, input bit hi);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) r[4*i +: 4] = hi ? w[8*i+4 +: 4] : w[8*i +: 4];
    return r;
  endfunction

  // Reference model for u_c: a queue of whole entries, plus the beat phase and the sticky flags.
  logic [23:0] m_q[$];
  bit          m_phase, m_ovf, m_unf;
  logic [11:0] m_qexp;

  task automatic model_reset();
    m_q.delete();
    m_phase = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_qexp  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  // Drive one cycle on u_c, update the model from pre-edge state, and compare.
  task automatic c_step(input bit wr, input logic [23:0] d, input bit rd, input string tag);
    bit full_pre, empty_pre;
    c_wren = wr; c_d = d; c_rden = rd;
    full_pre  = (m_q.size() == 8);
    empty_pre = (m_q.size() == 0);
    if (rd) begin
      if (empty_pre) m_unf = 1'b1;
      else if (!m_phase) begin
        m_qexp  = nib3(m_q[0], 1'b0);
        m_phase = 1'b1;
      end else begin
        m_qexp  = nib3(m_q[0], 1'b1);
        void'(m_q.pop_front());
        m_phase = 1'b0;
      end
    end
    if (wr) begin
      if (full_pre) m_ovf = 1'b1;
      else m_q.push_back(d);
    end
    tick();
    c_wren = 1'b0; c_rden = 1'b0;
    checks++;
    if (c_q !== m_qexp) begin
      errors++;
      $display("FAIL %s c_q: got %h want %h", tag, c_q, m_qexp);
    end
    checks++;
    if (c_st !== st8(m_q.size(), m_ovf, m_unf)) begin
      errors++;
      $display("FAIL %s c_status: got %b want %b", tag, c_st, st8(m_q.size(), m_ovf, m_unf));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_st !== st4(0, 0, 0) || a_q !== 8'h00) begin
      errors++; $display("FAIL reset_async_a: got %b/%h want %b/00", a_st, a_q, st4(0, 0, 0));
    end
    checks++;
    if (b_st !== st4(0, 0, 0) || b_q !== 8'h00) begin
      errors++; $display("FAIL reset_async_b: got %b/%h want %b/00", b_st, b_q, st4(0, 0, 0));
    end
    checks++;
    if (c_st !== st8(0, 0, 0) || c_q !== 12'h000) begin
      errors++; $display("FAIL reset_async_c: got %b/%h want %b/000", c_st, c_q, st8(0, 0, 0));
    end
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    checks++;
    if (a_st !== st4(0, 0, 0) || a_q !== 8'h00) begin
      errors++; $display("FAIL reset_release_a: got %b/%h want %b/00", a_st, a_q, st4(0, 0, 0));
    end
    checks++;
    if (c_st !== st8(0, 0, 0)) begin
      errors++; $display("FAIL reset_release_c: got %b want %b", c_st, st8(0, 0, 0));
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_q [4] = '{8'h12, 8'hAB, 8'h34, 8'hCD};
    int         exp_c [4] = '{2, 1, 1, 0};
    a_wren = 1'b1; a_d = 16'hA1B2;
    tick();
    a_d = 16'hC3D4;
    tick();
    a_wren = 1'b0;
    checks++;
    if (a_st !== st4(2, 0, 0)) begin
      errors++; $display("FAIL fill_status: got %b want %b", a_st, st4(2, 0, 0));
    end
    a_rden = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (a_q !== exp_q[k]) begin
        errors++; $display("FAIL drain_q beat %0d: got %h want %h", k, a_q, exp_q[k]);
      end
      checks++;
      if (a_st !== st4(exp_c[k], 0, 0)) begin
        errors++; $display("FAIL drain_status beat %0d: got %b want %b", k, a_st, st4(exp_c[k], 0, 0));
      end
    end
    a_rden = 1'b0;
    tick();
    checks++;
    if (a_q !== 8'hCD) begin
      errors++; $display("FAIL q_hold: got %h want cd", a_q);
    end
  endtask

  task automatic test_reset_mid_entry();
    a_wren = 1'b1; a_d = 16'h5678;
    tick();
    a_wren = 1'b0; a_rden = 1'b1;
    tick();
    a_rden = 1'b0;
    checks++;
    if (a_q !== 8'h68 || a_st !== st4(1, 0, 0)) begin
      errors++; $display("FAIL mid_low_beat: got %h/%b want 68/%b", a_q, a_st, st4(1, 0, 0));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_q !== 8'h00 || a_st !== st4(0, 0, 0)) begin
      errors++; $display("FAIL mid_reset: got %h/%b want 00/%b", a_q, a_st, st4(0, 0, 0));
    end
    tick();
    rst = 1'b0;
    model_reset();
    a_wren = 1'b1; a_d = 16'h9ABC;
    tick();
    a_wren = 1'b0; a_rden = 1'b1;
    tick();
    checks++;
    if (a_q !== 8'hAC || a_st !== st4(1, 0, 0)) begin
      errors++; $display("FAIL post_reset_low: got %h/%b want ac/%b", a_q, a_st, st4(1, 0, 0));
    end
    tick();
    a_rden = 1'b0;
    checks++;
    if (a_q !== 8'h9B || a_st !== st4(0, 0, 0)) begin
      errors++; $display("FAIL post_reset_high: got %h/%b want 9b/%b", a_q, a_st, st4(0, 0, 0));
    end
  endtask

  task automatic test_overflow();
    logic [15:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = 16'($urandom);
    b_wren = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_d = w[i];
      tick();
      if (i == 3) begin
        checks++;
        if (b_st !== st4(4, 0, 0)) begin
          errors++; $display("FAIL ovf_full: got %b want %b", b_st, st4(4, 0, 0));
        end
      end
    end
    b_wren = 1'b0;
    checks++;
    if (b_st !== st4(4, 1, 0)) begin
      errors++; $display("FAIL ovf_flag: got %b want %b", b_st, st4(4, 1, 0));
    end
    b_rden = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (b_q !== lo2(w[i]) || b_st !== st4(3 - i, 1, 0)) begin
        errors++; $display("FAIL ovf_drain %0d: got %h/%b want %h/%b", i, b_q, b_st, lo2(w[i]), st4(3 - i, 1, 0));
      end
    end
    b_rden = 1'b0;
  endtask

  task automatic test_underflow();
    tick();
    checks++;
    if (b_q !== 8'h00) begin
      errors++; $display("FAIL od_idle_q: got %h want 00", b_q);
    end
    b_rden = 1'b1;
    tick();
    b_rden = 1'b0;
    checks++;
    if (b_q !== 8'h00 || b_st !== st4(0, 1, 1)) begin
      errors++; $display("FAIL unf_flag: got %h/%b want 00/%b", b_q, b_st, st4(0, 1, 1));
    end
    b_wren = 1'b1; b_d = 16'h5AC3;
    tick();
    b_wren = 1'b0; b_rden = 1'b1;
    tick();
    b_rden = 1'b0;
    checks++;
    if (b_q !== 8'hA3 || b_st !== st4(0, 1, 1)) begin
      errors++; $display("FAIL unf_sticky: got %h/%b want a3/%b", b_q, b_st, st4(0, 1, 1));
    end
    tick();
    checks++;
    if (b_q !== 8'h00) begin
      errors++; $display("FAIL od_gate: got %h want 00", b_q);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] w [6];
    logic [15:0] tail [3];
    for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
    do_reset();
    b_wren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_d = w[i];
      tick();
    end
    b_d = w[3]; b_rden = 1'b1;
    tick();
    b_rden = 1'b0;
    checks++;
    if (b_st !== st4(3, 0, 0) || b_q !== lo2(w[0])) begin
      errors++; $display("FAIL sim_at_dm1: got %b/%h want %b/%h", b_st, b_q, st4(3, 0, 0), lo2(w[0]));
    end
    b_d = w[4];
    tick();
    checks++;
    if (b_st !== st4(4, 0, 0)) begin
      errors++; $display("FAIL sim_refill: got %b want %b", b_st, st4(4, 0, 0));
    end
    b_d = w[5]; b_rden = 1'b1;
    tick();
    b_wren = 1'b0; b_rden = 1'b0;
    checks++;
    if (b_st !== st4(3, 1, 0) || b_q !== lo2(w[1])) begin
      errors++; $display("FAIL sim_at_full: got %b/%h want %b/%h", b_st, b_q, st4(3, 1, 0), lo2(w[1]));
    end
    tail = '{w[2], w[3], w[4]};
    b_rden = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b_q !== lo2(tail[i]) || b_st !== st4(2 - i, 1, 0)) begin
        errors++; $display("FAIL sim_drain %0d: got %h/%b want %h/%b", i, b_q, b_st, lo2(tail[i]), st4(2 - i, 1, 0));
      end
    end
    b_rden = 1'b0;
  endtask

  task automatic test_thresholds();
    for (int i = 0; i < 9; i++) c_step(1'b1, 24'($urandom), 1'b0, "thr_fill");
    for (int i = 0; i < 16; i++) c_step(1'b0, '0, 1'b1, "thr_drain");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      c_step(1'b1, 24'($urandom), 1'b0, "wrap_wr");
      c_step(1'b0, '0, 1'b1, "wrap_lo");
      c_step(1'b0, '0, 1'b1, "wrap_hi");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      c_step(($urandom_range(0, 99) < 55), 24'($urandom), ($urandom_range(0, 99) < 60), "random");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_reset_mid_entry();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_thresholds();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
